// File: rtl/tx_frame_sched_pkg.sv
// Mux select codes, scheduler FSM states and lane geometry for the x4 TX framing path.
package tx_frame_sched_pkg;

  localparam int LANES = 4;
  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  localparam logic [3:0] CTRL_COM = 4'd0;
  localparam logic [3:0] CTRL_PAD = 4'd1;
  localparam logic [3:0] CTRL_SKP = 4'd2;
  localparam logic [3:0] CTRL_STP = 4'd3;
  localparam logic [3:0] CTRL_SDP = 4'd4;
  localparam logic [3:0] CTRL_END = 4'd5;
  localparam logic [3:0] CTRL_EDB = 4'd6;
  localparam logic [3:0] CTRL_FTS = 4'd7;
  localparam logic [3:0] CTRL_IDL = 4'd8;
  localparam logic [3:0] CTRL_TLP = 4'd9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SKP,
    ST_DSDP,
    ST_DDAT,
    ST_DEND,
    ST_TSTP,
    ST_TDAT,
    ST_TEND,
    ST_PAD
  } state_t;

  // Symbol driven while the FSM sits in a state; the SKP OS leads with COM on lane 0.
  function automatic logic [3:0] sym_code(input state_t st, input logic [1:0] sym,
                                          input logic nullified);
    logic [3:0] code;
    code = CTRL_IDL;
    case (st)
      ST_SKP:           code = (sym == 2'd0) ? CTRL_COM : CTRL_SKP;
      ST_DSDP:          code = CTRL_SDP;
      ST_TSTP:          code = CTRL_STP;
      ST_DDAT, ST_TDAT: code = CTRL_TLP;
      ST_DEND:          code = CTRL_END;
      ST_TEND:          code = nullified ? CTRL_EDB : CTRL_END;
      ST_PAD:           code = CTRL_PAD;
      default:          code = CTRL_IDL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tx_frame_sched_skp_timer.sv
// SKP ordered-set interval timer: raises pend every INTERVAL enabled cycles, held until clr.
// An expiry coinciding with clr keeps pend set so no interval is lost.
module tx_frame_sched_skp_timer #(
  parameter int INTERVAL = 1180
) (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic clr,
  output logic pend
);

  localparam int TW = $clog2(INTERVAL);

  logic [TW-1:0] tmr;
  logic          expire;

  assign expire = enb && (tmr == TW'(INTERVAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr  <= '0;
      pend <= 1'b0;
    end else begin
      if (enb) begin
        tmr <= expire ? '0 : tmr + TW'(1);
      end
      if (expire) begin
        pend <= 1'b1;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// TX framing scheduler: lane-0 aligned IDL/SKP/DLLP/TLP sequencing into the x4 mux; registered outputs, 1-cycle latency.
// IN_ENB low freezes all state; define TX_NULLIFY_EN to let IN_ABORT end a TLP with EDB.
module tx_frame_sched
  import tx_frame_sched_pkg::*;
#(
  parameter int LEN_W        = 8,
  parameter int SKP_INTERVAL = 1180,
  parameter int DLLP_LEN     = 6
) (
  input  logic             CLK_1MHz,
  input  logic             IN_RESET_CLK,
  input  logic             IN_ENB,
  input  logic             IN_TLP_REQ,
  input  logic [LEN_W-1:0] IN_TLP_LEN,
  input  logic             IN_DLLP_REQ,
  input  logic             IN_ABORT,
  output logic             OUT_TLP_GNT,
  output logic             OUT_DLLP_GNT,
  output logic             OUT_DATA_RD,
  output logic [3:0]       OUT_CTRL,
  output logic             OUT_ENB,
  output logic             OUT_BUSY
);

  state_t           state, state_nxt;
  logic [1:0]       sym_ctr, sym_nxt;
  logic [LEN_W-1:0] len_ctr, len_nxt;
  logic             nullified, null_nxt;
  logic             skp_pend, skp_clr;
  logic             tlp_gnt_nxt, dllp_gnt_nxt, rd_nxt, busy_nxt;
  logic [3:0]       ctrl_nxt;
  logic             abort_hit;

`ifdef TX_NULLIFY_EN
  assign abort_hit = IN_ABORT;
`else
  logic unused_abort;
  assign unused_abort = IN_ABORT;
  assign abort_hit    = 1'b0;
`endif

  tx_frame_sched_skp_timer #(
    .INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk (CLK_1MHz),
    .rst (IN_RESET_CLK),
    .enb (IN_ENB),
    .clr (skp_clr),
    .pend(skp_pend)
  );

  // len_ctr counts payload symbols still to send after the one being issued.
  always_comb begin
    state_nxt    = state;
    sym_nxt      = sym_ctr + 2'd1;
    len_nxt      = len_ctr;
    null_nxt     = nullified;
    skp_clr      = 1'b0;
    tlp_gnt_nxt  = 1'b0;
    dllp_gnt_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (sym_ctr == LAST_LANE) begin
          if (skp_pend) begin
            state_nxt = ST_SKP;
            skp_clr   = 1'b1;
          end else if (IN_DLLP_REQ) begin
            state_nxt    = ST_DSDP;
            dllp_gnt_nxt = 1'b1;
            len_nxt      = LEN_W'(DLLP_LEN);
          end else if (IN_TLP_REQ && (IN_TLP_LEN != '0)) begin
            state_nxt   = ST_TSTP;
            tlp_gnt_nxt = 1'b1;
            len_nxt     = IN_TLP_LEN;
            null_nxt    = 1'b0;
          end
        end
      end
      ST_SKP: begin
        if (sym_ctr == LAST_LANE) state_nxt = ST_IDLE;
      end
      ST_DSDP: begin
        state_nxt = ST_DDAT;
        len_nxt   = len_ctr - LEN_W'(1);
      end
      ST_DDAT: begin
        if (len_ctr == '0) state_nxt = ST_DEND;
        else               len_nxt   = len_ctr - LEN_W'(1);
      end
      ST_TSTP: begin
        state_nxt = ST_TDAT;
        len_nxt   = len_ctr - LEN_W'(1);
      end
      ST_TDAT: begin
        if (abort_hit) begin
          state_nxt = ST_TEND;
          null_nxt  = 1'b1;
        end else if (len_ctr == '0) begin
          state_nxt = ST_TEND;
        end else begin
          len_nxt = len_ctr - LEN_W'(1);
        end
      end
      ST_DEND, ST_TEND: begin
        state_nxt = (sym_ctr == LAST_LANE) ? ST_IDLE : ST_PAD;
      end
      ST_PAD: begin
        if (sym_ctr == LAST_LANE) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (!IN_ENB) begin
      state_nxt    = state;
      sym_nxt      = sym_ctr;
      len_nxt      = len_ctr;
      null_nxt     = nullified;
      skp_clr      = 1'b0;
      tlp_gnt_nxt  = 1'b0;
      dllp_gnt_nxt = 1'b0;
    end

    // A frozen cycle recomputes the same symbol, so OUT_CTRL holds naturally.
    ctrl_nxt = sym_code(state_nxt, sym_nxt, null_nxt);
    rd_nxt   = IN_ENB && ((state_nxt == ST_TDAT) || (state_nxt == ST_DDAT));
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge CLK_1MHz) begin
    if (IN_RESET_CLK) begin
      state        <= ST_IDLE;
      sym_ctr      <= '0;
      len_ctr      <= '0;
      nullified    <= 1'b0;
      OUT_CTRL     <= CTRL_IDL;
      OUT_ENB      <= 1'b0;
      OUT_TLP_GNT  <= 1'b0;
      OUT_DLLP_GNT <= 1'b0;
      OUT_DATA_RD  <= 1'b0;
      OUT_BUSY     <= 1'b0;
    end else begin
      state        <= state_nxt;
      sym_ctr      <= sym_nxt;
      len_ctr      <= len_nxt;
      nullified    <= null_nxt;
      OUT_CTRL     <= ctrl_nxt;
      OUT_ENB      <= IN_ENB;
      OUT_TLP_GNT  <= tlp_gnt_nxt;
      OUT_DLLP_GNT <= dllp_gnt_nxt;
      OUT_DATA_RD  <= rd_nxt;
      OUT_BUSY     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched: one DUT at the default SKP interval, one at SKP_INTERVAL=8.
// Expected symbol streams are hand-built as {ctrl, dllp_gnt, tlp_gnt, rd, busy} per cycle.
module tb_tx_frame_sched;

  localparam logic [3:0] C_COM = 4'd0;
  localparam logic [3:0] C_PAD = 4'd1;
  localparam logic [3:0] C_SKP = 4'd2;
  localparam logic [3:0] C_STP = 4'd3;
  localparam logic [3:0] C_SDP = 4'd4;
  localparam logic [3:0] C_END = 4'd5;
  localparam logic [3:0] C_EDB = 4'd6;
  localparam logic [3:0] C_IDL = 4'd8;
  localparam logic [3:0] C_TLP = 4'd9;

  // low nibble of an expected entry: {dllp_gnt, tlp_gnt, rd, busy}
  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_DGNT = 4'b1001;
  localparam logic [3:0] F_TGNT = 4'b0101;
  localparam logic [3:0] F_RD   = 4'b0011;
  localparam logic [3:0] F_BUSY = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, enb = 1'b1, tlp_req = 1'b0, dllp_req = 1'b0, abort = 1'b0;
  logic [7:0] tlp_len = 8'd0;
  logic       tlp_gnt, dllp_gnt, data_rd, out_enb, busy;
  logic [3:0] ctrl;

  logic       s_rst = 1'b1, s_enb = 1'b1, s_tlp_req = 1'b0, s_dllp_req = 1'b0, s_abort = 1'b0;
  logic [7:0] s_tlp_len = 8'd0;
  logic       s_tlp_gnt, s_dllp_gnt, s_data_rd, s_out_enb, s_busy;
  logic [3:0] s_ctrl;

  int n_vec = 0;
  int n_err = 0;

  tx_frame_sched dut (
    .CLK_1MHz    (clk),
    .IN_RESET_CLK(rst),
    .IN_ENB      (enb),
    .IN_TLP_REQ  (tlp_req),
    .IN_TLP_LEN  (tlp_len),
    .IN_DLLP_REQ (dllp_req),
    .IN_ABORT    (abort),
    .OUT_TLP_GNT (tlp_gnt),
    .OUT_DLLP_GNT(dllp_gnt),
    .OUT_DATA_RD (data_rd),
    .OUT_CTRL    (ctrl),
    .OUT_ENB     (out_enb),
    .OUT_BUSY    (busy)
  );

  tx_frame_sched #(.SKP_INTERVAL(8)) dut_skp (
    .CLK_1MHz    (clk),
    .IN_RESET_CLK(s_rst),
    .IN_ENB      (s_enb),
    .IN_TLP_REQ  (s_tlp_req),
    .IN_TLP_LEN  (s_tlp_len),
    .IN_DLLP_REQ (s_dllp_req),
    .IN_ABORT    (s_abort),
    .OUT_TLP_GNT (s_tlp_gnt),
    .OUT_DLLP_GNT(s_dllp_gnt),
    .OUT_DATA_RD (s_data_rd),
    .OUT_CTRL    (s_ctrl),
    .OUT_ENB     (s_out_enb),
    .OUT_BUSY    (s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Three reset edges; afterwards the next edge is enabled edge 1 (sym_ctr 0 -> 1).
  task automatic do_reset();
    rst = 1'b1; enb = 1'b1; tlp_req = 1'b0; dllp_req = 1'b0; abort = 1'b0; tlp_len = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (ctrl !== C_IDL) begin
      n_err++; $display("FAIL reset_ctrl: got %0d want %0d", ctrl, C_IDL);
    end
    n_vec++;
    if ({tlp_gnt, dllp_gnt, data_rd, busy, out_enb} !== 5'b00000) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000", {tlp_gnt, dllp_gnt, data_rd, busy, out_enb});
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_vec++;
      if ({ctrl, busy, out_enb, data_rd} !== {C_IDL, 3'b010}) begin
        n_err++; $display("FAIL idle_fill cyc%0d: ctrl/busy/enb/rd got %0d/%b/%b/%b want 8/0/1/0", i, ctrl, busy, out_enb, data_rd);
      end
    end
  endtask

  task automatic test_tlp_len3();
    logic [7:0] ex[$];
    int n_rd = 0;
    do_reset();
    tlp_req = 1'b1; tlp_len = 8'd3;
    repeat (3) ex.push_back({C_IDL, F_IDLE});
    ex.push_back({C_STP, F_TGNT});
    repeat (3) ex.push_back({C_TLP, F_RD});
    ex.push_back({C_END, F_BUSY});
    repeat (3) ex.push_back({C_PAD, F_BUSY});
    ex.push_back({C_IDL, F_IDLE});
    for (int i = 0; i < ex.size(); i++) begin
      tick();
      if (tlp_gnt) tlp_req = 1'b0;
      if (data_rd) n_rd++;
      n_vec++;
      if ({ctrl, dllp_gnt, tlp_gnt, data_rd, busy} !== ex[i]) begin
        n_err++; $display("FAIL tlp_len3 cyc%0d: {ctrl,dg,tg,rd,busy} got %h want %h", i + 1, {ctrl, dllp_gnt, tlp_gnt, data_rd, busy}, ex[i]);
      end
    end
    n_vec++;
    if (n_rd != 3) begin
      n_err++; $display("FAIL tlp_len3_rd_count: got %0d want 3", n_rd);
    end
  endtask

  task automatic test_dllp_vs_tlp();
    logic [7:0] ex[$];
    do_reset();
    dllp_req = 1'b1; tlp_req = 1'b1; tlp_len = 8'd2;
    repeat (3) ex.push_back({C_IDL, F_IDLE});
    ex.push_back({C_SDP, F_DGNT});
    repeat (6) ex.push_back({C_TLP, F_RD});
    ex.push_back({C_END, F_BUSY});
    repeat (4) ex.push_back({C_IDL, F_IDLE});
    ex.push_back({C_STP, F_TGNT});
    repeat (2) ex.push_back({C_TLP, F_RD});
    ex.push_back({C_END, F_BUSY});
    ex.push_back({C_IDL, F_IDLE});
    for (int i = 0; i < ex.size(); i++) begin
      tick();
      if (dllp_gnt) dllp_req = 1'b0;
      if (tlp_gnt) tlp_req = 1'b0;
      n_vec++;
      if ({ctrl, dllp_gnt, tlp_gnt, data_rd, busy} !== ex[i]) begin
        n_err++; $display("FAIL dllp_vs_tlp cyc%0d: {ctrl,dg,tg,rd,busy} got %h want %h", i + 1, {ctrl, dllp_gnt, tlp_gnt, data_rd, busy}, ex[i]);
      end
    end
  endtask

  // A zero-length TLP request must not block a later DLLP.
  task automatic test_len_zero();
    logic [7:0] ex[$];
    do_reset();
    tlp_req = 1'b1; tlp_len = 8'd0;
    repeat (11) ex.push_back({C_IDL, F_IDLE});
    ex.push_back({C_SDP, F_DGNT});
    for (int i = 0; i < ex.size(); i++) begin
      if (i == 8) dllp_req = 1'b1;
      tick();
      if (dllp_gnt) dllp_req = 1'b0;
      n_vec++;
      if ({ctrl, dllp_gnt, tlp_gnt, data_rd, busy} !== ex[i]) begin
        n_err++; $display("FAIL len_zero cyc%0d: {ctrl,dg,tg,rd,busy} got %h want %h", i + 1, {ctrl, dllp_gnt, tlp_gnt, data_rd, busy}, ex[i]);
      end
    end
    tlp_req = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] ex[$];
    do_reset();
    dllp_req = 1'b1;
    repeat (6) begin
      tick();
      if (dllp_gnt) dllp_req = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({ctrl, busy, data_rd, out_enb} !== {C_IDL, 3'b000}) begin
      n_err++; $display("FAIL reset_mid_frame: ctrl/busy/rd/enb got %0d/%b/%b/%b want 8/0/0/0", ctrl, busy, data_rd, out_enb);
    end
    dllp_req = 1'b1;
    repeat (3) ex.push_back({C_IDL, F_IDLE});
    ex.push_back({C_SDP, F_DGNT});
    for (int i = 0; i < ex.size(); i++) begin
      tick();
      if (dllp_gnt) dllp_req = 1'b0;
      n_vec++;
      if ({ctrl, dllp_gnt, tlp_gnt, data_rd, busy} !== ex[i]) begin
        n_err++; $display("FAIL after_mid_reset cyc%0d: {ctrl,dg,tg,rd,busy} got %h want %h", i + 1, {ctrl, dllp_gnt, tlp_gnt, data_rd, busy}, ex[i]);
      end
    end
  endtask

  // Abort sampled while the 2nd payload symbol is on the bus.
  task automatic test_nullify();
    logic [7:0] ex[$];
    do_reset();
    tlp_req = 1'b1; tlp_len = 8'd10;
    repeat (3) ex.push_back({C_IDL, F_IDLE});
    ex.push_back({C_STP, F_TGNT});
`ifdef TX_NULLIFY_EN
    repeat (2) ex.push_back({C_TLP, F_RD});
    ex.push_back({C_EDB, F_BUSY});   // EDB lands on lane 3, so no PAD follows
`else
    repeat (10) ex.push_back({C_TLP, F_RD});
    ex.push_back({C_END, F_BUSY});
`endif
    repeat (2) ex.push_back({C_IDL, F_IDLE});
    for (int i = 0; i < ex.size(); i++) begin
      abort = (i == 6);
      tick();
      if (tlp_gnt) tlp_req = 1'b0;
      n_vec++;
      if ({ctrl, dllp_gnt, tlp_gnt, data_rd, busy} !== ex[i]) begin
        n_err++; $display("FAIL nullify cyc%0d: {ctrl,dg,tg,rd,busy} got %h want %h", i + 1, {ctrl, dllp_gnt, tlp_gnt, data_rd, busy}, ex[i]);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_enb_freeze();
    logic [7:0] ex[$];
    int n_rd = 0;
    do_reset();
    tlp_req = 1'b1; tlp_len = 8'd6;
    repeat (3) ex.push_back({C_IDL, F_IDLE});
    ex.push_back({C_STP, F_TGNT});
    repeat (2) ex.push_back({C_TLP, F_RD});
    repeat (5) ex.push_back({C_TLP, F_BUSY});
    repeat (4) ex.push_back({C_TLP, F_RD});
    ex.push_back({C_END, F_BUSY});
    ex.push_back({C_IDL, F_IDLE});
    for (int i = 0; i < ex.size(); i++) begin
      enb = !(i >= 6 && i <= 10);
      tick();
      if (tlp_gnt) tlp_req = 1'b0;
      if (data_rd) n_rd++;
      n_vec++;
      if ({ctrl, dllp_gnt, tlp_gnt, data_rd, busy, out_enb} !== {ex[i], !(i >= 6 && i <= 10)}) begin
        n_err++; $display("FAIL enb_freeze cyc%0d: {ctrl,dg,tg,rd,busy,enb} got %h want %h", i + 1, {ctrl, dllp_gnt, tlp_gnt, data_rd, busy, out_enb}, {ex[i], !(i >= 6 && i <= 10)});
      end
    end
    n_vec++;
    if (n_rd != 6) begin
      n_err++; $display("FAIL enb_freeze_rd_count: got %0d want 6", n_rd);
    end
  endtask

  // SKP interval 8: pend rises at edge 8 while the TLP is granted, so the OS follows the frame.
  task automatic test_skp_deferred();
    logic [7:0] ex[$];
    s_rst = 1'b1;
    repeat (3) tick();
    s_rst = 1'b0;
    repeat (7) ex.push_back({C_IDL, F_IDLE});
    ex.push_back({C_STP, F_TGNT});
    repeat (20) ex.push_back({C_TLP, F_RD});
    ex.push_back({C_END, F_BUSY});
    repeat (2) ex.push_back({C_PAD, F_BUSY});
    repeat (4) ex.push_back({C_IDL, F_IDLE});
    ex.push_back({C_COM, F_BUSY});
    repeat (3) ex.push_back({C_SKP, F_BUSY});
    ex.push_back({C_IDL, F_IDLE});
    for (int i = 0; i < ex.size(); i++) begin
      if (i == 4) begin
        s_tlp_req = 1'b1; s_tlp_len = 8'd20;
      end
      tick();
      if (s_tlp_gnt) s_tlp_req = 1'b0;
      n_vec++;
      if ({s_ctrl, s_dllp_gnt, s_tlp_gnt, s_data_rd, s_busy} !== ex[i]) begin
        n_err++; $display("FAIL skp_deferred cyc%0d: {ctrl,dg,tg,rd,busy} got %h want %h", i + 1, {s_ctrl, s_dllp_gnt, s_tlp_gnt, s_data_rd, s_busy}, ex[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tlp_len3();
    test_dllp_vs_tlp();
    test_len_zero();
    test_reset_mid_frame();
    test_nullify();
    test_enb_freeze();
    test_skp_deferred();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
